// File: rtl/ram_pkg.sv
// ram_pkg: shared types and elaboration-time helpers for the replicated
// multi-read-port RAM (ram_nr1w) and its single bank (ram_1r1w).
//   state_t    : controller state, INIT (sweeping) or RUN (array usable)
//   depth_of() : number of words addressed by an address of a given width
//   slice_lo() : low bit of element idx inside a flattened bus of w-bit elements
package ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/ram_1r1w.sv
// ram_1r1w: one storage bank with a synchronous write port and a registered
// read port. The read register can be loaded with the word being written in
// the same cycle (fwd=1), which gives write-first behaviour when the caller
// has detected an address match.
//   clk, rst           : clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata   : write port
//   re, raddr          : read request; rdata loads only when re=1, else holds
//   fwd                : load wdata instead of the stored word
//   rdata              : registered read data
module ram_1r1w
    import ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              fwd,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; its
    // contents are made defined by the controller's init sweep instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= fwd ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/ram_nr1w.sv
// ram_nr1w: NUM_RD-read / 1-write RAM built from NUM_RD replicated 1R1W
// banks. Every write goes to all banks; read port i is served by bank i.
// After reset or a clr request the controller sweeps INIT_VAL into every
// word (DEPTH cycles) before raising ready.
//   clk, rst                     : clock, asynchronous active-low reset
//   clr                          : restart the init sweep
//   ready                        : 1 once the array is initialised
//   w_enb_1, w_addr_1, w_din_1   : write port
//   r_en[i], r_addr slice i      : read request for port i
//   r_dout slice i, r_vld[i]     : read data (1-cycle latency) and its valid flag
module ram_nr1w
    import ram_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 11,
    parameter int                NUM_RD   = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    output logic                     ready,
    input  logic                     w_enb_1,
    input  logic [ADDR_W-1:0]        w_addr_1,
    input  logic [DATA_W-1:0]        w_din_1,
    input  logic [NUM_RD-1:0]        r_en,
    input  logic [NUM_RD*ADDR_W-1:0] r_addr,
    output logic [NUM_RD*DATA_W-1:0] r_dout,
    output logic [NUM_RD-1:0]        r_vld
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              run;

    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [DATA_W-1:0] bank_wdata;

    assign run = (state_q == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready   <= (state_d == RUN);
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // The sweep owns the write port during INIT; user writes are dropped.
    always_comb begin
        bank_we    = 1'b1;
        bank_waddr = cnt_q;
        bank_wdata = INIT_VAL;
        if (run) begin
            bank_we    = w_enb_1;
            bank_waddr = w_addr_1;
            bank_wdata = w_din_1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= run ? r_en : '0;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_bank
        logic [ADDR_W-1:0] raddr;
        logic              re;
        logic              fwd;

        assign raddr = r_addr[slice_lo(g, ADDR_W) +: ADDR_W];
        assign re    = run && r_en[g];
        // Same-cycle write to the address being read returns the new word.
        assign fwd   = run && w_enb_1 && (raddr == w_addr_1);

        ram_1r1w #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (re),
            .raddr (raddr),
            .fwd   (fwd),
            .rdata (r_dout[slice_lo(g, DATA_W) +: DATA_W])
        );
    end

endmodule

// File: tb/tb_ram_nr1w.sv
// tb_ram_nr1w: directed bench for ram_nr1w. Two instances (4 read ports and
// 2 read ports, ADDR_W=4) share the write port and the low read ports. A
// behavioural model (word array plus remaining-sweep-cycles count) predicts
// ready / r_vld / r_dout every cycle; literal checks pin the model.
module tb_ram_nr1w;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 4;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             w_enb_1;
    logic [AW-1:0]    w_addr_1;
    logic [DW-1:0]    w_din_1;
    logic [NR-1:0]    r_en;
    logic [NR*AW-1:0] r_addr;

    logic             ready4;
    logic [NR*DW-1:0] r_dout4;
    logic [NR-1:0]    r_vld4;
    logic             ready2;
    logic [2*DW-1:0]  r_dout2;
    logic [1:0]       r_vld2;

    int tests = 0;
    int fails = 0;
    bit cmp_on = 0;

    ram_nr1w #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .INIT_VAL('0)) u_dut4 (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready4),
        .w_enb_1(w_enb_1), .w_addr_1(w_addr_1), .w_din_1(w_din_1),
        .r_en(r_en), .r_addr(r_addr), .r_dout(r_dout4), .r_vld(r_vld4)
    );

    ram_nr1w #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .INIT_VAL('0)) u_dut2 (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready2),
        .w_enb_1(w_enb_1), .w_addr_1(w_addr_1), .w_din_1(w_din_1),
        .r_en(r_en[1:0]), .r_addr(r_addr[2*AW-1:0]), .r_dout(r_dout2), .r_vld(r_vld2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [16];
    logic [DW-1:0] m_dout [NR];
    logic [NR-1:0] m_vld;
    logic          m_ready;
    int            m_left;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready = 1'b0;
            m_vld   = '0;
            m_left  = 16;
            for (int i = 0; i < NR; i++) m_dout[i] = '0;
        end else if (!m_ready) begin
            m_vld = '0;
            if (clr) begin
                m_left = 16;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    for (int a = 0; a < 16; a++) m_mem[a] = '0;
                    m_ready = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NR; i++) begin
                m_vld[i] = r_en[i];
                if (r_en[i]) begin
                    if (w_enb_1 && r_addr[i*AW +: AW] == w_addr_1)
                        m_dout[i] = w_din_1;
                    else
                        m_dout[i] = m_mem[r_addr[i*AW +: AW]];
                end
            end
            if (w_enb_1) m_mem[w_addr_1] = w_din_1;
            if (clr) begin
                m_ready = 1'b0;
                m_left  = 16;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            check("ready4", 32'(ready4), 32'(m_ready));
            check("ready2", 32'(ready2), 32'(m_ready));
            check("vld4", 32'(r_vld4), 32'(m_vld));
            check("vld2", 32'(r_vld2), 32'(m_vld[1:0]));
            for (int i = 0; i < NR; i++)
                check($sformatf("dout4_p%0d", i), r_dout4[i*DW +: DW], m_dout[i]);
            for (int i = 0; i < 2; i++)
                check($sformatf("dout2_p%0d", i), r_dout2[i*DW +: DW], m_dout[i]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr     = 1'b0;
        w_enb_1 = 1'b0;
        r_en    = '0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready4 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        w_enb_1  = 1'b1;
        w_addr_1 = a;
        w_din_1  = d;
    endtask

    int n;

    initial begin
        rst = 1'b0; clr = 1'b0; w_enb_1 = 1'b0; w_addr_1 = '0; w_din_1 = '0;
        r_en = '0; r_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp_on = 1'b1;
        check("rst_ready", 32'(ready4), 32'd0);
        check("rst_vld", 32'(r_vld4), 32'd0);
        check("rst_dout0", r_dout4[31:0], 32'd0);

        // Init sweep after reset release: 16 cycles exactly.
        rst = 1'b1;
        wait_ready(n);
        check("init_cycles", 32'(n), 32'd16);

        // Every word reads INIT_VAL on all ports.
        for (int a = 0; a < 16; a++) begin
            r_en   = 4'hf;
            r_addr = {4{4'(a)}};
            tick();
        end
        check("init_word15_p3", r_dout4[3*DW +: DW], 32'd0);
        check("init_vld", 32'(r_vld4), 32'hf);
        idle();

        // Replicated write then read on two ports.
        wr(4'd5, 32'hDEADBEEF); tick();
        wr(4'd9, 32'h12345678); tick();
        w_enb_1 = 1'b0;
        r_en = 4'b0011; r_addr = {4'd0, 4'd0, 4'd9, 4'd5};
        tick();
        check("rd_d0", r_dout4[31:0], 32'hDEADBEEF);
        check("rd_d1", r_dout4[63:32], 32'h12345678);
        check("rd_vld", 32'(r_vld4), 32'h3);
        check("rd2_d1", r_dout2[63:32], 32'h12345678);

        // Bypass on port 0, plain read of word 4 on port 1.
        wr(4'd3, 32'hCAFEF00D);
        r_en = 4'b0011; r_addr = {4'd0, 4'd0, 4'd4, 4'd3};
        tick();
        check("byp_d0", r_dout4[31:0], 32'hCAFEF00D);
        check("byp_d1", r_dout4[63:32], 32'd0);
        idle(); w_din_1 = 32'h0;
        tick();
        check("hold_vld", 32'(r_vld4), 32'd0);
        check("hold_d0", r_dout4[31:0], 32'hCAFEF00D);

        // clr mid-operation: word 7 returns to INIT_VAL.
        wr(4'd7, 32'hAAAA5555); tick();
        idle(); tick(); tick(); tick();
        clr = 1'b1; tick();
        clr = 1'b0;
        check("clr_ready_low", 32'(ready4), 32'd0);
        wait_ready(n);
        check("clr_sweep", 32'(n), 32'd16);
        r_en = 4'b0001; r_addr = {12'd0, 4'd7};
        tick();
        check("clr_word7", r_dout4[31:0], 32'd0);
        idle();

        // Writes and reads during INIT are ignored (issued after the sweep
        // has passed word 2, so a leaked write would survive).
        clr = 1'b1; tick();
        clr = 1'b0;
        repeat (10) tick();
        for (int k = 0; k < 5; k++) begin
            wr(4'd2, 32'hFFFFFFFF);
            r_en = 4'hf; r_addr = {4{4'd2}};
            tick();
            check("init_ign_vld", 32'(r_vld4), 32'd0);
        end
        idle();
        wait_ready(n);
        check("init_ign_rest", 32'(n), 32'd1);
        r_en = 4'b0011; r_addr = {8'd0, 4'd2, 4'd2};
        tick();
        check("init_ign_word2", r_dout4[31:0], 32'd0);
        idle();

        // Four ports reading one address, then four-way bypass.
        wr(4'd12, 32'h5A5A0001); tick();
        w_enb_1 = 1'b0;
        r_en = 4'hf; r_addr = {4{4'd12}};
        tick();
        for (int i = 0; i < NR; i++)
            check($sformatf("same_addr_p%0d", i), r_dout4[i*DW +: DW], 32'h5A5A0001);
        wr(4'd12, 32'h0BADC0DE);
        tick();
        for (int i = 0; i < NR; i++)
            check($sformatf("byp4_p%0d", i), r_dout4[i*DW +: DW], 32'h0BADC0DE);
        idle();

        // Asynchronous reset mid-operation clears outputs at once.
        #2 rst = 1'b0;
        #1;
        check("arst_ready", 32'(ready4), 32'd0);
        check("arst_vld", 32'(r_vld4), 32'd0);
        check("arst_dout0", r_dout4[31:0], 32'd0);
        tick();
        rst = 1'b1;
        repeat (8) tick();
        // Sweep counter is at 8: abort and restart.
        #2 rst = 1'b0;
        #1;
        check("arst_mid_ready", 32'(ready4), 32'd0);
        tick();
        rst = 1'b1;
        wait_ready(n);
        check("arst_resweep", 32'(n), 32'd16);
        r_en = 4'hf; r_addr = {4{4'd12}};
        tick();
        check("arst_word12", r_dout4[DW +: DW], 32'd0);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
